// File: rtl/texture_read_arbiter.sv
// texture_read_arbiter: round-robin sharing of one 256-bit texture read port, returning 128-bit rows via a 2-entry FIFO.
// Define TEX_ARB_PERF_CNT_EN to add saturating grant/stall counters.
module texture_read_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int READ_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   i_req_valid,
    input  logic [NUM_REQ*8-1:0] i_req_texture_idx,
    input  logic [NUM_REQ*4-1:0] i_req_row_idx,
    output logic [NUM_REQ-1:0]   o_req_ready,
    output logic [7:0]           o_mem_texture_idx,
    output logic [3:0]           o_mem_row_idx,
    input  logic [255:0]         i_mem_data,
    output logic                 o_rsp_valid,
    output logic [2:0]           o_rsp_id,
    output logic [127:0]         o_rsp_data,
    input  logic                 i_rsp_ready
`ifdef TEX_ARB_PERF_CNT_EN
    ,
    output logic [31:0]          o_perf_grants,
    output logic [31:0]          o_perf_stalls
`endif
);
    localparam int D = 1 + READ_LATENCY;

    logic [2:0]   ptr_q, gnt_idx, cand;
    logic         gnt_vld, issue_ok, hs, push, pop;
    logic [7:0]   vld_ext;
    logic [63:0]  tex_ext;
    logic [31:0]  row_ext;
    logic [7:0]   sel_tex;
    logic [3:0]   sel_row;
    logic [2:0]   inflight;
    logic [D-1:0] pv_q, ph_q;
    logic [2:0]   pid_q [D];
    logic [130:0] fifo_q [2];
    logic         wr_q, rd_q;
    logic [1:0]   cnt_q, cnt_d;
    logic [7:0]   mem_tex_q;
    logic [3:0]   mem_row_q;

    assign vld_ext = 8'(i_req_valid);
    assign tex_ext = 64'(i_req_texture_idx);
    assign row_ext = 32'(i_req_row_idx);

    // Walk downward so the requester closest after the pointer wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = 3'((int'(ptr_q) + i) % NUM_REQ);
            if (vld_ext[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    always_comb begin
        inflight = '0;
        for (int i = 0; i < D; i++) inflight = inflight + 3'(pv_q[i]);
    end

    // Credits cover both buffered and in-flight reads so the FIFO can never overflow.
    assign issue_ok    = rst_n && ((3'(cnt_q) + inflight) < 3'd2);
    assign hs          = gnt_vld && issue_ok;
    assign o_req_ready = hs ? NUM_REQ'(1) << gnt_idx : '0;
    assign sel_tex     = tex_ext[{gnt_idx, 3'b000} +: 8];
    assign sel_row     = row_ext[{gnt_idx, 2'b00} +: 4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q     <= 3'(NUM_REQ - 1);
            mem_tex_q <= '0;
            mem_row_q <= '0;
        end else if (hs) begin
            ptr_q     <= gnt_idx;
            mem_tex_q <= sel_tex;
            mem_row_q <= sel_row;
        end
    end

    assign o_mem_texture_idx = mem_tex_q;
    assign o_mem_row_idx     = mem_row_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv_q <= '0;
            ph_q <= '0;
            for (int i = 0; i < D; i++) pid_q[i] <= '0;
        end else begin
            pv_q     <= {pv_q[D-2:0], hs};
            ph_q     <= {ph_q[D-2:0], sel_row[0]};
            pid_q[0] <= gnt_idx;
            for (int i = 1; i < D; i++) pid_q[i] <= pid_q[i-1];
        end
    end

    assign push  = pv_q[D-1];
    assign pop   = o_rsp_valid && i_rsp_ready;
    assign cnt_d = cnt_q + 2'(push) - 2'(pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            cnt_q     <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_q] <= {pid_q[D-1], ph_q[D-1] ? i_mem_data[255:128] : i_mem_data[127:0]};
                wr_q         <= ~wr_q;
            end
            if (pop) rd_q <= ~rd_q;
            cnt_q <= cnt_d;
        end
    end

    assign o_rsp_valid            = cnt_q != 2'd0;
    assign {o_rsp_id, o_rsp_data} = fifo_q[rd_q];

`ifdef TEX_ARB_PERF_CNT_EN
    logic [31:0] grants_q, stalls_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grants_q <= '0;
            stalls_q <= '0;
        end else begin
            if (hs && grants_q != '1) grants_q <= grants_q + 32'd1;
            if (|i_req_valid && !hs && stalls_q != '1) stalls_q <= stalls_q + 32'd1;
        end
    end

    assign o_perf_grants = grants_q;
    assign o_perf_stalls = stalls_q;
`endif
endmodule
